// File: rtl/wishbone_slave_pkg.sv
// Purpose : shared types and constants for the wishbone register slave.
// Latency : n/a (package only).
// Backpressure : n/a.
// Contents: FSM state encoding, register index constants, bus/event widths.
package wishbone_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DAT_W       = 32;
  localparam int EVT_W       = 8;
  localparam int CNT_W       = 4;

  localparam int REG_CTRL    = 0;
  localparam int REG_STATUS  = 1;
  localparam int CTRL_INT_EN = 0;

endpackage

// File: rtl/wishbone_slave_regs_if.sv
// Purpose : wishbone slave-side bus bundle (address, data, strobe, ack).
// Latency : n/a (wires only).
// Backpressure : slave stalls the master simply by withholding wbs_ack_o.
// Modports: slave (the register block), master (the host side / bench).
interface wishbone_slave_regs_if;
  import wishbone_slave_pkg::*;

  logic [DAT_W-1:0] wbs_adr_i;
  logic [DAT_W-1:0] wbs_dat_i;
  logic [DAT_W-1:0] wbs_dat_o;
  logic             wbs_stb_i;
  logic             wbs_cyc_i;
  logic             wbs_we_i;
  logic             wbs_msk_i;
  logic             wbs_sel_i;
  logic             wbs_ack_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_msk_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_msk_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o
  );

endinterface

// File: rtl/wishbone_slave_regfile.sv
// Purpose : register array with write port, read mux and optional W1C status.
// Latency : write lands on the edge wr_en_i is high; rdat_o is combinational.
// Backpressure : none; always accepts a write.
// Ports   : clk, rst (sync, active-high), wr_en_i/idx_i/wdat_i write port,
//           idx_i also selects rdat_o, user_event_i status set inputs, int_o.
// Build   : WBS_INTERRUPT_EN enables reg0 bit0 enable + reg1 status/interrupt.
module wishbone_slave_regfile
  import wishbone_slave_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [DAT_W-1:0] wdat_i,
  input  logic [EVT_W-1:0] user_event_i,
  output logic [DAT_W-1:0] rdat_o,
  output logic             int_o
);

  logic [DAT_W-1:0] regs_q [NUM_REGS];
  logic [DAT_W-1:0] regs_d [NUM_REGS];

`ifdef WBS_INTERRUPT_EN
  logic [EVT_W-1:0] clr;
  logic             int_q;

  assign clr = (wr_en_i && (idx_i == IDX_W'(REG_STATUS))) ? wdat_i[EVT_W-1:0] : '0;

  // Interrupt is computed from registered state, so it trails status/enable by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_q <= 1'b0;
    end else begin
      int_q <= regs_q[REG_CTRL][CTRL_INT_EN] & (|regs_q[REG_STATUS][EVT_W-1:0]);
    end
  end

  assign int_o = int_q;
`else
  logic unused_evt;
  assign unused_evt = ^user_event_i;
  assign int_o      = 1'b0;
`endif

  always_comb begin
    regs_d = regs_q;
    if (wr_en_i) begin
      regs_d[idx_i] = wdat_i;
    end
`ifdef WBS_INTERRUPT_EN
    // Status overrides the plain write: W1C, with a same-cycle event winning over the clear.
    regs_d[REG_STATUS] = {{(DAT_W-EVT_W){1'b0}},
                          (regs_q[REG_STATUS][EVT_W-1:0] & ~clr) | user_event_i};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdat_o = regs_q[idx_i];

endmodule

// File: rtl/wishbone_slave_regs.sv
// Purpose : wishbone slave decoding one window onto a 32-bit register bank.
// Latency : ack rises ACK_DELAY+1 edges after the edge that samples stb&cyc.
// Backpressure : ack withheld during the delay; dropping stb/cyc in WAIT aborts.
// Ports   : clk, rst (sync, active-high), wbs (slave modport of
//           wishbone_slave_regs_if), user_event (8 level events), wbs_int_o.
// Build   : define WBS_INTERRUPT_EN for the interrupt/status block.
module wishbone_slave_regs
  import wishbone_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          NUM_REGS  = 8,
  parameter int          ACK_DELAY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  wishbone_slave_regs_if.slave       wbs,
  input  logic [EVT_W-1:0]           user_event,
  output logic                       wbs_int_o
);

  localparam int               IDX_W    = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (ACK_DELAY > 0) ? CNT_W'(ACK_DELAY - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DAT_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdat_q, wdat_d;
  logic             we_q, we_d;
  logic             ack_q, ack_d;
  logic [DAT_W-1:0] rdat_q, rdat_d;

  logic             req;
  logic [DAT_W-1:0] idx_full;
  logic             hit;
  logic             wr_en;
  logic [DAT_W-1:0] rd_dat;
  logic             unused_bus;

  assign req      = wbs.wbs_stb_i & wbs.wbs_cyc_i;
  // Wrapping subtract: addresses below the base become huge and fall out of range.
  assign idx_full = adr_q - ADDR_BASE;
  assign hit      = idx_full < DAT_W'(NUM_REGS);
  assign wr_en    = (state_q == ST_ACK) && we_q && hit;

  assign unused_bus = wbs.wbs_msk_i ^ wbs.wbs_sel_i;

  wishbone_slave_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .idx_i        (idx_full[IDX_W-1:0]),
    .wdat_i       (wdat_q),
    .user_event_i (user_event),
    .rdat_o       (rd_dat),
    .int_o        (wbs_int_o)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d  = wbs.wbs_adr_i;
          wdat_d = wbs.wbs_dat_i;
          we_d   = wbs.wbs_we_i;
          if (ACK_DELAY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        // Commit edge: write lands in the regfile, read data and ack register together.
        ack_d   = 1'b1;
        if (!we_q) begin
          rdat_d = hit ? rd_dat : '0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Hold here until stb drops so a lingering strobe cannot start a second cycle.
        if (!wbs.wbs_stb_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdat_q;

endmodule
